// File: rtl/alu_exec_pipe_pkg.sv
// Shared constants, op-class encoding and instruction decode for the ALU execution pipe.
package alu_exec_pipe_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [4:0] {
    OC_ADD, OC_SUB, OC_SLL, OC_SLT, OC_SLTU, OC_XOR, OC_SRL, OC_SRA, OC_OR, OC_AND,
    OC_LUI, OC_AUIPC, OC_JAL, OC_JALR,
    OC_BEQ, OC_BNE, OC_BLT, OC_BGE, OC_BLTU, OC_BGEU,
    OC_ILLEGAL
  } op_class_e;

  // OP and OP-IMM share funct3 decode; only OP lets inst[30] turn ADD into SUB.
  function automatic op_class_e decode_op(input logic [31:0] inst);
    op_class_e oc;
    logic      is_op;
    oc    = OC_ILLEGAL;
    is_op = (inst[6:0] == OPC_OP);
    case (inst[6:0])
      OPC_OP, OPC_OP_IMM: begin
        case (inst[14:12])
          F3_ADD:  oc = (is_op && inst[30]) ? OC_SUB : OC_ADD;
          F3_SLL:  oc = OC_SLL;
          F3_SLT:  oc = OC_SLT;
          F3_SLTU: oc = OC_SLTU;
          F3_XOR:  oc = OC_XOR;
          F3_SR:   oc = inst[30] ? OC_SRA : OC_SRL;
          F3_OR:   oc = OC_OR;
          F3_AND:  oc = OC_AND;
          default: oc = OC_ILLEGAL;
        endcase
      end
      OPC_LUI:   oc = OC_LUI;
      OPC_AUIPC: oc = OC_AUIPC;
      OPC_JAL:   oc = OC_JAL;
      OPC_JALR:  oc = OC_JALR;
      OPC_BRANCH: begin
        case (inst[14:12])
          F3_BEQ:  oc = OC_BEQ;
          F3_BNE:  oc = OC_BNE;
          F3_BLT:  oc = OC_BLT;
          F3_BGE:  oc = OC_BGE;
          F3_BLTU: oc = OC_BLTU;
          F3_BGEU: oc = OC_BGEU;
          default: oc = OC_ILLEGAL;
        endcase
      end
      default: oc = OC_ILLEGAL;
    endcase
    return oc;
  endfunction

endpackage

// File: rtl/alu_exec_pipe_alu_core.sv
// Combinational result unit: op class plus operands give rd value, taken flag and target.
module alu_core
  import alu_exec_pipe_pkg::*;
#(
  parameter int XLEN_P = XLEN
) (
  input  op_class_e         i_op,
  input  logic [XLEN_P-1:0] i_a,
  input  logic [XLEN_P-1:0] i_b,
  input  logic [XLEN_P-1:0] i_pc,
  input  logic [XLEN_P-1:0] i_imme,
  output logic [XLEN_P-1:0] o_value,
  output logic              o_taken,
  output logic [XLEN_P-1:0] o_target,
  output logic              o_illegal
);

  logic [XLEN_P-1:0] w_pc4;
  logic [XLEN_P-1:0] w_pc_imm;
  logic [4:0]        w_shamt;
  logic              w_is_br;
  logic              w_br_cond;

  assign w_pc4    = i_pc + 32'd4;
  assign w_pc_imm = i_pc + i_imme;
  assign w_shamt  = i_b[4:0];

  // Result select; branch conditions fold into taken/target after the case.
  always_comb begin
    o_value   = '0;
    o_taken   = 1'b0;
    o_target  = w_pc4;
    o_illegal = 1'b0;
    w_is_br   = 1'b0;
    w_br_cond = 1'b0;
    case (i_op)
      OC_ADD:   o_value = i_a + i_b;
      OC_SUB:   o_value = i_a - i_b;
      OC_SLL:   o_value = i_a << w_shamt;
      OC_SLT:   o_value = {{(XLEN_P-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OC_SLTU:  o_value = {{(XLEN_P-1){1'b0}}, (i_a < i_b)};
      OC_XOR:   o_value = i_a ^ i_b;
      OC_SRL:   o_value = i_a >> w_shamt;
      OC_SRA:   o_value = $unsigned($signed(i_a) >>> w_shamt);
      OC_OR:    o_value = i_a | i_b;
      OC_AND:   o_value = i_a & i_b;
      OC_LUI:   o_value = i_imme;
      OC_AUIPC: o_value = w_pc_imm;
      OC_JAL: begin
        o_value  = w_pc4;
        o_taken  = 1'b1;
        o_target = w_pc_imm;
      end
      OC_JALR: begin
        o_value  = w_pc4;
        o_taken  = 1'b1;
        o_target = (i_a + i_imme) & ~32'd1;
      end
      OC_BEQ:  begin w_is_br = 1'b1; w_br_cond = (i_a == i_b); end
      OC_BNE:  begin w_is_br = 1'b1; w_br_cond = (i_a != i_b); end
      OC_BLT:  begin w_is_br = 1'b1; w_br_cond = ($signed(i_a) < $signed(i_b)); end
      OC_BGE:  begin w_is_br = 1'b1; w_br_cond = ($signed(i_a) >= $signed(i_b)); end
      OC_BLTU: begin w_is_br = 1'b1; w_br_cond = (i_a < i_b); end
      OC_BGEU: begin w_is_br = 1'b1; w_br_cond = (i_a >= i_b); end
      OC_ILLEGAL: o_illegal = 1'b1;
      default:    o_illegal = 1'b1;
    endcase
    o_taken  = o_taken | (w_is_br & w_br_cond);
    o_target = (w_is_br && w_br_cond) ? w_pc_imm : o_target;
  end

endmodule

// File: rtl/alu_exec_pipe.sv
// Two-stage ALU execution pipe: S1 decodes and latches the issue, S2 registers the CDB broadcast.
module alu_exec_pipe
  import alu_exec_pipe_pkg::*;
#(
  parameter int XLEN_P  = XLEN,
  parameter int TAG_W_P = TAG_W
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [31:0]        in_inst,
  input  logic [XLEN_P-1:0]  in_pc,
  input  logic [XLEN_P-1:0]  in_rs1_val,
  input  logic [XLEN_P-1:0]  in_rs2_val,
  input  logic [XLEN_P-1:0]  in_imme,
  input  logic [TAG_W_P-1:0] in_tag,
  output logic               cdb_valid,
  output logic [TAG_W_P-1:0] cdb_tag,
  output logic [XLEN_P-1:0]  cdb_value,
  output logic               cdb_br_taken,
  output logic [XLEN_P-1:0]  cdb_br_target,
  output logic               cdb_illegal
);

  logic               r_s1_valid;
  op_class_e          r_s1_op;
  logic [XLEN_P-1:0]  r_s1_a;
  logic [XLEN_P-1:0]  r_s1_b;
  logic [XLEN_P-1:0]  r_s1_pc;
  logic [XLEN_P-1:0]  r_s1_imme;
  logic [TAG_W_P-1:0] r_s1_tag;

  op_class_e          w_op;
  logic [XLEN_P-1:0]  w_b;
  logic               w_accept;
  logic [XLEN_P-1:0]  w_value;
  logic               w_taken;
  logic [XLEN_P-1:0]  w_target;
  logic               w_illegal;

  assign w_op     = decode_op(in_inst);
  assign w_accept = in_valid && (in_tag != '0);

  // Register-register ops and branches take rs2 as the second operand; the rest use the immediate.
  always_comb begin
    w_b = in_imme;
    if ((in_inst[6:0] == OPC_OP) || (in_inst[6:0] == OPC_BRANCH)) begin
      w_b = in_rs2_val;
    end else begin
      w_b = in_imme;
    end
  end

  // S1: capture a tagged issue; flush wins over issue.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OC_ILLEGAL;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_pc    <= '0;
      r_s1_imme  <= '0;
      r_s1_tag   <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        r_s1_valid <= 1'b0;
      end else begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_op   <= w_op;
          r_s1_a    <= in_rs1_val;
          r_s1_b    <= w_b;
          r_s1_pc   <= in_pc;
          r_s1_imme <= in_imme;
          r_s1_tag  <= in_tag;
        end
      end
    end
  end

  alu_core #(.XLEN_P(XLEN_P)) u_alu_core (
    .i_op      (r_s1_op),
    .i_a       (r_s1_a),
    .i_b       (r_s1_b),
    .i_pc      (r_s1_pc),
    .i_imme    (r_s1_imme),
    .o_value   (w_value),
    .o_taken   (w_taken),
    .o_target  (w_target),
    .o_illegal (w_illegal)
  );

  // S2: broadcast register; an empty S1 or a flush zeroes the whole lane.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid     <= 1'b0;
      cdb_tag       <= '0;
      cdb_value     <= '0;
      cdb_br_taken  <= 1'b0;
      cdb_br_target <= '0;
      cdb_illegal   <= 1'b0;
    end else if (rdy_in) begin
      if (r_s1_valid && !clear) begin
        cdb_valid     <= 1'b1;
        cdb_tag       <= r_s1_tag;
        cdb_value     <= w_value;
        cdb_br_taken  <= w_taken;
        cdb_br_target <= w_target;
        cdb_illegal   <= w_illegal;
      end else begin
        cdb_valid     <= 1'b0;
        cdb_tag       <= '0;
        cdb_value     <= '0;
        cdb_br_taken  <= 1'b0;
        cdb_br_target <= '0;
        cdb_illegal   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed scoreboard bench for alu_exec_pipe.
module tb_alu_exec_pipe;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic [31:0] in_imme;
  logic [4:0]  in_tag;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        cdb_br_taken;
  logic [31:0] cdb_br_target;
  logic        cdb_illegal;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] value;
    logic        taken;
    logic [31:0] target;
    logic        illegal;
  } exp_t;

  exp_t sb[$];

  alu_exec_pipe dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imme(in_imme), .in_tag(in_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_br_taken(cdb_br_taken), .cdb_br_target(cdb_br_target), .cdb_illegal(cdb_illegal)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (cdb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {31'd0, cdb_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("tag",     {27'd0, cdb_tag},      {27'd0, e.tag});
        chk("value",   cdb_value,             e.value);
        chk("taken",   {31'd0, cdb_br_taken}, {31'd0, e.taken});
        chk("target",  cdb_br_target,         e.target);
        chk("illegal", {31'd0, cdb_illegal},  {31'd0, e.illegal});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    check_out();
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
    in_rs1_val = 32'd0; in_rs2_val = 32'd0; in_imme = 32'd0; in_tag = 5'd0;
  endtask

  // Drive one issue for one cycle; optionally record its expected broadcast.
  task automatic issue(input logic [4:0] tag, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imme,
                       input bit push, input logic [31:0] ev, input logic et,
                       input logic [31:0] etgt, input logic eill);
    exp_t e;
    in_valid = 1'b1; in_tag = tag; in_inst = inst; in_pc = pc;
    in_rs1_val = rs1; in_rs2_val = rs2; in_imme = imme;
    if (push) begin
      e.tag = tag; e.value = ev; e.taken = et; e.target = etgt; e.illegal = eill;
      sb.push_back(e);
    end
    tick();
    drive_idle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    drive_idle();
    #3;
    chk("rst_valid",  {31'd0, cdb_valid},    32'd0);
    chk("rst_value",  cdb_value,             32'd0);
    chk("rst_tag",    {27'd0, cdb_tag},      32'd0);
    chk("rst_taken",  {31'd0, cdb_br_taken}, 32'd0);
    chk("rst_target", cdb_br_target,         32'd0);
    chk("rst_ill",    {31'd0, cdb_illegal},  32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    idle(2);

    // ADD latency: visible only after the second edge, for exactly one cycle
    issue(5'd3, 32'h0000_0033, 32'd0, 32'd7, 32'd5, 32'd0, 1, 32'd12, 1'b0, 32'd4, 1'b0);
    chk("add_lat0", {31'd0, cdb_valid}, 32'd0);
    tick();
    chk("add_lat1", {31'd0, cdb_valid}, 32'd1);
    tick();
    chk("add_lat2", {31'd0, cdb_valid}, 32'd0);

    // Back-to-back directed ops
    issue(5'd1,  32'h4000_0033, 32'd0, 32'h8000_0000, 32'd1, 32'd0, 1, 32'h7FFF_FFFF, 1'b0, 32'd4, 1'b0);
    issue(5'd2,  32'h4000_5033, 32'd0, 32'h8000_0000, 32'd1, 32'd0, 1, 32'hC000_0000, 1'b0, 32'd4, 1'b0);
    issue(5'd3,  32'h0000_5033, 32'd0, 32'h8000_0000, 32'd1, 32'd0, 1, 32'h4000_0000, 1'b0, 32'd4, 1'b0);
    issue(5'd4,  32'h0000_2033, 32'd0, 32'h8000_0000, 32'd1, 32'd0, 1, 32'd1, 1'b0, 32'd4, 1'b0);
    issue(5'd5,  32'h0000_3033, 32'd0, 32'h8000_0000, 32'd1, 32'd0, 1, 32'd0, 1'b0, 32'd4, 1'b0);
    issue(5'd6,  32'h4000_0013, 32'd0, 32'd7, 32'd99, 32'h0000_0400, 1, 32'h0000_0407, 1'b0, 32'd4, 1'b0);
    issue(5'd7,  32'h4010_5013, 32'd0, 32'h8000_0000, 32'd0, 32'h0000_0401, 1, 32'hC000_0000, 1'b0, 32'd4, 1'b0);
    issue(5'd8,  32'h0000_4063, 32'h100, 32'hFFFF_FFFF, 32'd0, 32'h20, 1, 32'd0, 1'b1, 32'h120, 1'b0);
    issue(5'd9,  32'h0000_6063, 32'h100, 32'hFFFF_FFFF, 32'd0, 32'h20, 1, 32'd0, 1'b0, 32'h104, 1'b0);
    issue(5'd10, 32'h0000_0067, 32'h40, 32'h1003, 32'd0, 32'd2, 1, 32'h44, 1'b1, 32'h1004, 1'b0);
    issue(5'd11, 32'h1234_5037, 32'h200, 32'd0, 32'd0, 32'h1234_5000, 1, 32'h1234_5000, 1'b0, 32'h204, 1'b0);
    issue(5'd12, 32'h0000_1017, 32'h200, 32'd0, 32'd0, 32'h1000, 1, 32'h1200, 1'b0, 32'h204, 1'b0);
    issue(5'd13, 32'h0000_006F, 32'h300, 32'd0, 32'd0, 32'hFFFF_FFF0, 1, 32'h304, 1'b1, 32'h2F0, 1'b0);
    issue(5'd14, 32'h0050_0063, 32'h80, 32'd5, 32'd5, 32'd8, 1, 32'd0, 1'b1, 32'h88, 1'b0);
    issue(5'd15, 32'h0000_2003, 32'h500, 32'd1, 32'd2, 32'd4, 1, 32'd0, 1'b0, 32'h504, 1'b1);
    issue(5'd0,  32'h0000_0033, 32'd0, 32'd1, 32'd1, 32'd0, 0, 32'd0, 1'b0, 32'd0, 1'b0);
    idle(3);

    // Four back-to-back tags
    for (int t = 1; t <= 4; t++)
      issue(t[4:0], 32'h0000_0033, 32'd0, t, 32'd100, 32'd0, 1, t + 100, 1'b0, 32'd4, 1'b0);
    idle(3);

    // Flush at the third issue: only tag 1 may be broadcast
    issue(5'd1, 32'h0000_0033, 32'd0, 32'd1, 32'd1, 32'd0, 1, 32'd2, 1'b0, 32'd4, 1'b0);
    issue(5'd2, 32'h0000_0033, 32'd0, 32'd2, 32'd1, 32'd0, 0, 32'd0, 1'b0, 32'd0, 1'b0);
    clear = 1'b1;
    issue(5'd3, 32'h0000_0033, 32'd0, 32'd3, 32'd1, 32'd0, 0, 32'd0, 1'b0, 32'd0, 1'b0);
    chk("clear_valid", {31'd0, cdb_valid}, 32'd0);
    issue(5'd4, 32'h0000_0033, 32'd0, 32'd4, 32'd1, 32'd0, 0, 32'd0, 1'b0, 32'd0, 1'b0);
    clear = 1'b0;
    idle(4);

    // Asynchronous reset mid-stream
    issue(5'd5, 32'h0000_0033, 32'd0, 32'd5, 32'd5, 32'd0, 1, 32'd10, 1'b0, 32'd4, 1'b0);
    issue(5'd6, 32'h0000_0033, 32'd0, 32'd6, 32'd6, 32'd0, 1, 32'd12, 1'b0, 32'd4, 1'b0);
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst_valid", {31'd0, cdb_valid}, 32'd0);
    chk("arst_tag",   {27'd0, cdb_tag},   32'd0);
    chk("arst_value", cdb_value,          32'd0);
    sb.delete();
    tick();
    @(negedge clk_in);
    rst_in = 1'b1;
    idle(3);

    // Three-cycle stall with a live result; issue and flush must be ignored meanwhile
    issue(5'd7, 32'h0000_0033, 32'd0, 32'd1, 32'd2, 32'd0, 1, 32'd3, 1'b0, 32'd4, 1'b0);
    issue(5'd8, 32'h0000_4033, 32'd0, 32'd6, 32'd3, 32'd0, 1, 32'd5, 1'b0, 32'd4, 1'b0);
    rdy_in = 1'b0; clear = 1'b1;
    in_valid = 1'b1; in_tag = 5'd10; in_inst = 32'h0000_0033; in_rs1_val = 32'd9;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in);
      #1;
      chk("stall_valid", {31'd0, cdb_valid}, 32'd1);
      chk("stall_tag",   {27'd0, cdb_tag},   32'd7);
      chk("stall_value", cdb_value,          32'd3);
    end
    rdy_in = 1'b1; clear = 1'b0;
    drive_idle();
    tick();
    idle(3);

    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
